// File: rtl/voice_sched_pkg.sv
// Shared types and constants for the voice event scheduler.
`ifndef VOICE_SCHED_PKG_SV
`define VOICE_SCHED_PKG_SV

`define VS_VOICE(slot, vw, ew) slot[(vw)+(ew)-1:(ew)]
`define VS_ENV(slot, ew) slot[(ew)-1:0]

package voice_sched_pkg;

  localparam logic [1:0] EV_NOTE_OFF = 2'd0;
  localparam logic [1:0] EV_NOTE_ON  = 2'd1;
  localparam logic [1:0] EV_KILL     = 2'd2;
  localparam logic [1:0] EV_RSVD     = 2'd3;

  typedef enum logic [1:0] {
    STB_NONE = 2'd0,
    STB_TRIG = 2'd1,
    STB_KILL = 2'd2
  } strobe_t;

  function automatic int unsigned xxxx_max(input int unsigned voices,
                                           input int unsigned v_envs);
    return voices * v_envs - 1;
  endfunction

endpackage

`endif

// File: rtl/voice_evt_fifo.sv
// Small synchronous event FIFO; pointers carry an extra wrap bit for full/empty.
module voice_evt_fifo #(
  parameter int unsigned W          = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic         sCLK_XVXENVS,
  input  logic         iRST_N,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW+1)'(1);

  logic [W-1:0]     mem [FIFO_DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge sCLK_XVXENVS) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= din;
  end

endmodule

// File: rtl/voice_event_sched.sv
// Commits one buffered note event per frame and drives per-slot gate/velocity/strobes.
module voice_event_sched
  import voice_sched_pkg::*;
#(
  parameter int unsigned VOICES     = 8,
  parameter int unsigned V_ENVS     = 8,
  parameter int unsigned V_WIDTH    = 3,
  parameter int unsigned E_WIDTH    = 3,
  parameter int unsigned VEL_WIDTH  = 7,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic                       sCLK_XVXENVS,
  input  logic                       iRST_N,
  input  logic [V_WIDTH+E_WIDTH-1:0] iXXXX,
  input  logic                       ev_valid,
  output logic                       ev_ready,
  input  logic [V_WIDTH-1:0]         ev_voice,
  input  logic [1:0]                 ev_type,
  input  logic [VEL_WIDTH-1:0]       ev_vel,
  output logic [V_WIDTH+E_WIDTH-1:0] o_slot,
  output logic                       o_gate,
  output logic [VEL_WIDTH-1:0]       o_vel,
  output logic                       o_trig,
  output logic                       o_kill,
  output logic                       o_busy
);

  localparam int unsigned SW = V_WIDTH + E_WIDTH;
  localparam int unsigned FW = V_WIDTH + 2 + VEL_WIDTH;
  localparam logic [SW-1:0] SLOT_MAX = SW'(xxxx_max(VOICES, V_ENVS));

  logic                 boundary, push, pop, fifo_full, fifo_empty;
  logic [FW-1:0]        head;
  logic [V_WIDTH-1:0]   head_voice, slot_voice;
  logic [1:0]           head_type;
  logic [VEL_WIDTH-1:0] head_vel;

  strobe_t              strobe_q, strobe_d;
  logic [V_WIDTH-1:0]   cur_voice_q, cur_voice_d;
  logic [VOICES-1:0]    gate_q;
  logic [VEL_WIDTH-1:0] vel_q [VOICES];

  assign slot_voice = `VS_VOICE(iXXXX, V_WIDTH, E_WIDTH);
  assign boundary   = (iXXXX == SLOT_MAX);
  assign push       = ev_valid && !fifo_full;
  assign pop        = boundary && !fifo_empty;
  assign ev_ready   = !fifo_full;
  assign o_busy     = !fifo_empty || (strobe_q != STB_NONE);
  assign {head_voice, head_type, head_vel} = head;

  voice_evt_fifo #(
    .W          (FW),
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .sCLK_XVXENVS (sCLK_XVXENVS),
    .iRST_N       (iRST_N),
    .push         (push),
    .din          ({ev_voice, ev_type, ev_vel}),
    .pop          (pop),
    .dout         (head),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
    if (!iRST_N) begin
      strobe_q    <= STB_NONE;
      cur_voice_q <= '0;
    end else begin
      strobe_q    <= strobe_d;
      cur_voice_q <= cur_voice_d;
    end
  end

  always_comb begin
    strobe_d    = strobe_q;
    cur_voice_d = cur_voice_q;
    if (boundary) begin
      strobe_d = STB_NONE;
      if (!fifo_empty) begin
        cur_voice_d = head_voice;
        case (head_type)
          EV_NOTE_ON: strobe_d = STB_TRIG;
          EV_KILL:    strobe_d = STB_KILL;
          default:    strobe_d = STB_NONE;
        endcase
      end
    end
  end

  always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
    if (!iRST_N) begin
      gate_q <= '0;
      for (int unsigned i = 0; i < VOICES; i++) vel_q[i] <= '0;
    end else if (pop) begin
      case (head_type)
        EV_NOTE_ON: begin
          gate_q[head_voice] <= 1'b1;
          vel_q[head_voice]  <= head_vel;
        end
        EV_NOTE_OFF: gate_q[head_voice] <= 1'b0;
        EV_KILL: begin
          gate_q[head_voice] <= 1'b0;
          vel_q[head_voice]  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Reads pre-commit state at the boundary edge, so slot MAX closes out the old frame.
  always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
    if (!iRST_N) begin
      o_slot <= '0;
      o_gate <= 1'b0;
      o_vel  <= '0;
      o_trig <= 1'b0;
      o_kill <= 1'b0;
    end else begin
      o_slot <= iXXXX;
      o_gate <= gate_q[slot_voice];
      o_vel  <= vel_q[slot_voice];
      o_trig <= (strobe_q == STB_TRIG) && (slot_voice == cur_voice_q);
      o_kill <= (strobe_q == STB_KILL) && (slot_voice == cur_voice_q);
    end
  end

endmodule

// File: tb/tb_voice_event_sched.sv
// Bench for voice_event_sched: queue-based reference model, vector table, corner sequences.
`timescale 1ns/1ps
module tb_voice_event_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] slot;
  logic       ev_valid, ev_ready;
  logic [2:0] ev_voice;
  logic [1:0] ev_type;
  logic [6:0] ev_vel;
  logic [5:0] o_slot;
  logic       o_gate, o_trig, o_kill, o_busy;
  logic [6:0] o_vel;

  always #5 clk = ~clk;

  voice_event_sched #(
    .VOICES(8), .V_ENVS(8), .V_WIDTH(3), .E_WIDTH(3),
    .VEL_WIDTH(7), .FIFO_DEPTH(4), .FIFO_AW(2)
  ) dut (
    .sCLK_XVXENVS(clk), .iRST_N(rst_n), .iXXXX(slot),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_voice(ev_voice),
    .ev_type(ev_type), .ev_vel(ev_vel),
    .o_slot(o_slot), .o_gate(o_gate), .o_vel(o_vel),
    .o_trig(o_trig), .o_kill(o_kill), .o_busy(o_busy)
  );

  typedef struct { logic [2:0] v; logic [1:0] t; logic [6:0] vel; } ev_t;
  typedef struct {
    logic [2:0] v; logic [1:0] t; logic [6:0] vel; logic [2:0] pv;
    int g; int vl; int tr; int kl; int bs;
  } vec_t;

  // Reference model: event queue plus per-voice state; strobe 0=none 1=trig 2=kill
  ev_t  m_q[$];
  int   m_gate[8];
  int   m_vel[8];
  int   m_cur, m_stb;
  int   errors = 0, checks = 0;
  int   trig_cnt, trig_v;
  logic last_acc;
  logic [5:0] last_slot;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t slot=%0d)", name, act, exp, $time, slot);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 8; i++) begin m_gate[i] = 0; m_vel[i] = 0; end
    m_cur = 0;
    m_stb = 0;
  endtask

  task automatic tick();
    int  v, e_gate, e_vel, e_trig, e_kill;
    bit  acc, bnd;
    ev_t h;
    logic [5:0] s;
    s = slot;
    v = int'(slot[5:3]);
    e_gate = m_gate[v];
    e_vel  = m_vel[v];
    e_trig = (m_stb == 1 && v == m_cur) ? 1 : 0;
    e_kill = (m_stb == 2 && v == m_cur) ? 1 : 0;
    chk("ev_ready", int'(ev_ready), (m_q.size() < 4) ? 1 : 0);
    acc = ev_valid && (m_q.size() < 4);
    bnd = (slot == 6'd63);
    @(posedge clk);
    if (bnd) begin
      m_stb = 0;
      if (m_q.size() > 0) begin
        h = m_q.pop_front();
        m_cur = int'(h.v);
        case (h.t)
          2'd1: begin m_gate[h.v] = 1; m_vel[h.v] = int'(h.vel); m_stb = 1; end
          2'd0: m_gate[h.v] = 0;
          2'd2: begin m_gate[h.v] = 0; m_vel[h.v] = 0; m_stb = 2; end
          default: ;
        endcase
      end
    end
    if (acc) m_q.push_back('{ev_voice, ev_type, ev_vel});
    last_acc  = acc;
    last_slot = s;
    #1;
    chk("o_slot", int'(o_slot), int'(s));
    chk("o_gate", int'(o_gate), e_gate);
    chk("o_vel",  int'(o_vel),  e_vel);
    chk("o_trig", int'(o_trig), e_trig);
    chk("o_kill", int'(o_kill), e_kill);
    chk("o_busy", int'(o_busy), (m_q.size() > 0 || m_stb != 0) ? 1 : 0);
    if (o_trig) begin trig_cnt++; trig_v = int'(o_slot[5:3]); end
    slot = slot + 6'd1;
  endtask

  task automatic run_to(input logic [5:0] s);
    int n = 0;
    while (slot != s && n < 200) begin tick(); n++; end
    if (slot != s) begin
      errors++;
      $display("FAIL run_to: got slot %0d expected %0d", slot, s);
    end
  endtask

  task automatic push(input logic [2:0] v, input logic [1:0] t, input logic [6:0] vel);
    int n = 0;
    ev_voice = v; ev_type = t; ev_vel = vel; ev_valid = 1'b1;
    last_acc = 1'b0;
    while (!last_acc && n < 300) begin tick(); n++; end
    ev_valid = 1'b0;
    if (!last_acc) begin
      errors++;
      $display("FAIL push_timeout: got not-accepted expected accepted (voice %0d)", v);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_o_slot", int'(o_slot), 0);
    chk("rst_o_gate", int'(o_gate), 0);
    chk("rst_o_vel",  int'(o_vel),  0);
    chk("rst_o_trig", int'(o_trig), 0);
    chk("rst_o_kill", int'(o_kill), 0);
    chk("rst_ready",  int'(ev_ready), 1);
    chk("rst_busy",   int'(o_busy), 0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; slot = '0; ev_valid = 1'b0;
    ev_voice = '0; ev_type = '0; ev_vel = '0;
    trig_cnt = 0; trig_v = -1;
    model_reset();

    //            voice type  vel  probe gate vel  trig kill busy
    tbl[0] = '{3'd3, 2'd1, 7'd100, 3'd3, 1, 100, 1, 0, 1};
    tbl[1] = '{3'd5, 2'd1, 7'd20,  3'd5, 1, 20,  1, 0, 1};
    tbl[2] = '{3'd3, 2'd0, 7'd0,   3'd3, 0, 100, 0, 0, 0};
    tbl[3] = '{3'd7, 2'd1, 7'd50,  3'd7, 1, 50,  1, 0, 1};
    tbl[4] = '{3'd7, 2'd2, 7'd9,   3'd7, 0, 0,   0, 1, 1};
    tbl[5] = '{3'd5, 2'd3, 7'd9,   3'd5, 1, 20,  0, 0, 0};
    tbl[6] = '{3'd0, 2'd0, 7'd77,  3'd0, 0, 0,   0, 0, 0};
    tbl[7] = '{3'd0, 2'd1, 7'd127, 3'd0, 1, 127, 1, 0, 1};

    #12;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      run_to(6'd10);
      push(tbl[i].v, tbl[i].t, tbl[i].vel);
      run_to(6'd63);
      tick();
      chk("tbl_busy", int'(o_busy), tbl[i].bs);
      run_to({tbl[i].pv, 3'd3});
      tick();
      chk("tbl_gate", int'(o_gate), tbl[i].g);
      chk("tbl_vel",  int'(o_vel),  tbl[i].vl);
      chk("tbl_trig", int'(o_trig), tbl[i].tr);
      chk("tbl_kill", int'(o_kill), tbl[i].kl);
    end

    // Mid-frame reset with queued events: nothing survives
    run_to(6'd5);
    push(3'd1, 2'd1, 7'd11);
    push(3'd2, 2'd2, 7'd12);
    run_to(6'd20);
    do_reset();
    trig_cnt = 0;
    repeat (128) tick();
    chk("post_reset_trigs", trig_cnt, 0);

    // Five back-to-back pushes against a four-deep FIFO
    run_to(6'd10);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) trig_cnt = 0;
      push(3'(i), 2'd1, 7'(10 + i));
      if (i == 3) chk("ready_after4", int'(ev_ready), 0);
    end
    chk("fifth_accept_slot", int'(last_slot), 0);
    for (int f = 0; f < 5; f++) begin
      if (f > 0) trig_cnt = 0;
      repeat (f == 0 ? 63 : 64) tick();
      chk("burst_trig_cnt", trig_cnt, 8);
      chk("burst_trig_voice", trig_v, f);
    end

    // Push landing exactly on the boundary edge into an empty FIFO
    run_to(6'd63);
    push(3'd6, 2'd1, 7'd33);
    chk("edge_accept_slot", int'(last_slot), 63);
    trig_cnt = 0;
    repeat (64) tick();
    chk("edge_frame1_trigs", trig_cnt, 0);
    trig_cnt = 0;
    repeat (64) tick();
    chk("edge_frame2_trigs", trig_cnt, 8);
    chk("edge_frame2_voice", trig_v, 6);

    // Random traffic against the model
    repeat (2000) begin
      ev_valid = ($urandom_range(0, 7) == 0);
      ev_voice = 3'($urandom_range(0, 7));
      ev_type  = 2'($urandom_range(0, 3));
      ev_vel   = 7'($urandom_range(0, 127));
      tick();
    end
    ev_valid = 1'b0;
    repeat (200) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
